skein_nonce_scheduler: RTL

SKEIN_NONCE_SCHEDULER -- requirements
Module: skein_nonce_scheduler

---
 rtl/skein_nonce_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/skein_nonce_scheduler.sv
// Nonce sweep scheduler for a pipelined skein512 core: issues one nonce per cycle,
// tracks it through the core latency and buffers nonces whose hash meets the target.
module skein_nonce_scheduler #(
    parameter int PIPE_LAT   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [511:0] job_midstate,
    input  logic [95:0]  job_data,
    input  logic [63:0]  job_target,
    input  logic [31:0]  job_nonce_start,
    input  logic [31:0]  job_nonce_end,
    input  logic         abort,
    output logic [511:0] core_midstate,
    output logic [95:0]  core_data,
    output logic [31:0]  core_nonce,
    input  logic [511:0] core_hash,
    output logic         found_valid,
    input  logic         found_ready,
    output logic [31:0]  found_nonce,
    output logic         busy,
    output logic         done,
    output logic         overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_done_next;

    logic [511:0]    r_midstate;
    logic [95:0]     r_data;
    logic [63:0]     r_target;
    logic [31:0]     r_end;
    logic [31:0]     r_nonce;

    logic [PIPE_LAT-1:0] r_tag;
    logic [PIPE_LAT-1:0] w_tag_shift;
    logic [31:0]         r_trk_nonce [PIPE_LAT];

    logic [31:0]     r_fifo [FIFO_DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic [AW:0]     w_wr_ptr_next;
    logic [AW:0]     w_rd_ptr_next;
    logic [AW:0]     w_count;
    logic            r_found_valid;
    logic            r_done;
    logic            r_overflow;

    logic            w_accept;
    logic            w_abort;
    logic            w_issue;
    logic            w_last;
    logic            w_drained;
    logic            w_hit;
    logic            w_pop;
    logic            w_full;
    logic            w_push;
    logic            w_drop;
    logic            w_unused_hash;

    assign w_accept    = (r_state == S_IDLE) && job_valid;
    assign w_abort     = abort && (r_state != S_IDLE);
    assign w_issue     = (r_state == S_RUN) && !abort;
    assign w_last      = (r_nonce == r_end);
    assign w_tag_shift = r_tag << 1;
    // Drained once the only remaining tag (if any) is the one leaving the pipe this cycle.
    assign w_drained   = (w_tag_shift == '0);

    assign w_hit  = r_tag[PIPE_LAT-1] && !w_abort && (core_hash[511:448] <= r_target);
    assign w_unused_hash = ^core_hash[447:0];

    assign w_count       = r_wr_ptr - r_rd_ptr;
    assign w_full        = (w_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop         = r_found_valid && found_ready;
    assign w_push        = w_hit && (!w_full || w_pop);
    assign w_drop        = w_hit && w_full && !w_pop;
    assign w_wr_ptr_next = r_wr_ptr + (AW+1)'(w_push);
    assign w_rd_ptr_next = r_rd_ptr + (AW+1)'(w_pop);

    // NOTE: every combinational output gets a default before the case so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (job_valid) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (abort)       w_state_next = S_IDLE;
                else if (w_last) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (w_drained) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_midstate <= '0;
            r_data     <= '0;
            r_target   <= '0;
            r_end      <= '0;
            r_nonce    <= '0;
            r_overflow <= 1'b0;
            r_tag      <= '0;
        end else begin
            if (w_accept) begin
                r_midstate <= job_midstate;
                r_data     <= job_data;
                r_target   <= job_target;
                r_end      <= job_nonce_end;
                r_nonce    <= job_nonce_start;
                r_overflow <= 1'b0;
            end else begin
                if (w_issue && !w_last) r_nonce <= r_nonce + 32'd1;
                if (w_drop)             r_overflow <= 1'b1;
            end
            r_tag <= w_abort ? '0 : (w_tag_shift | PIPE_LAT'(w_issue));
        end
    end

    // NOTE: the tracked nonce values need no reset; only their valid tags qualify them.
    always_ff @(posedge clk) begin
        r_trk_nonce[0] <= r_nonce;
        for (int i = 1; i < PIPE_LAT; i++) begin
            r_trk_nonce[i] <= r_trk_nonce[i-1];
        end
    end

    // NOTE: the small found buffer is reset so found_nonce reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_found_valid <= 1'b0;
        end else begin
            if (w_push) r_fifo[r_wr_ptr[AW-1:0]] <= r_trk_nonce[PIPE_LAT-1];
            r_wr_ptr      <= w_wr_ptr_next;
            r_rd_ptr      <= w_rd_ptr_next;
            r_found_valid <= (w_wr_ptr_next != w_rd_ptr_next);
        end
    end

    assign job_ready     = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign overflow      = r_overflow;
    assign core_midstate = r_midstate;
    assign core_data     = r_data;
    assign core_nonce    = r_nonce;
    assign found_valid   = r_found_valid;
    assign found_nonce   = r_fifo[r_rd_ptr[AW-1:0]];

endmodule
